// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline hazard controller: mul/div sequencer
// state encoding, default latencies and the register-index match helper.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int DIV_CYCLES_DEF = 32;
  localparam int MUL_CYCLES_DEF = 4;
  localparam int CNT_W          = 5;

  // $zero is never a real producer, so index 0 never matches.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

endpackage

// File: rtl/md_seq.sv
// Multi-cycle mul/div sequencer: IDLE -> RUN (latency-1 cycles) -> DONE (one
// cycle). A start in RUN is ignored; a start in DONE chains straight into RUN.
module md_seq
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      is_div,
  output md_state_t state,
  output logic      busy,
  output logic      done
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

  md_state_t        state_r;
  md_state_t        state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             busy_r;
  logic             done_r;

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      MD_IDLE, MD_DONE: begin
        if (start) begin
          state_s = MD_RUN;
          cnt_s   = is_div ? DIV_LOAD : MUL_LOAD;
        end else begin
          state_s = MD_IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      end
      MD_RUN: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = MD_DONE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = MD_RUN;
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = MD_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and status flags; flags are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= MD_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s != MD_IDLE);
      done_r  <= (state_s == MD_DONE);
    end
  end

  assign state = state_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data/mul-div hazard detection and stall/flush
// priority. Forwarding-aware hazard rule selected by macro HAZARD_FWD_EN.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_Wants_Rs,
  input  logic       ID_Needs_Rs,
  input  logic       ID_Wants_Rt,
  input  logic       ID_Needs_Rt,
  input  logic       ID_MD_use,
  input  logic [4:0] EX_Rdst,
  input  logic [4:0] MEM_Rdst,
  input  logic       EX_RegW,
  input  logic       EX_MemR,
  input  logic       MEM_RegW,
  input  logic       MEM_MemR,
  input  logic       EX_MD_start,
  input  logic       EX_MD_is_div,
  input  logic       mem_busy,
  input  logic       ext_flush,
  output logic       PC_Stall,
  output logic       IF_ID_Stall,
  output logic       IF_ID_flush,
  output logic       ID_EX_Stall,
  output logic       ID_EX_flush,
  output logic       EX_MEM_Stall,
  output logic       MD_busy,
  output logic       MD_done,
  output logic [1:0] md_state
);

  md_state_t md_state_s;
  logic      rs_ex_s, rs_mem_s, rt_ex_s, rt_mem_s;
  logic      data_hazard_s;
  logic      md_hazard_s;
  logic      unused_s;

  md_seq #(
    .DIV_CYCLES(DIV_CYCLES),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_md_seq (
    .clk   (clk),
    .rst   (rst),
    .start (EX_MD_start),
    .is_div(EX_MD_is_div),
    .state (md_state_s),
    .busy  (MD_busy),
    .done  (MD_done)
  );

  assign md_state = md_state_s;

  assign rs_ex_s  = reg_match(ID_Rs, EX_Rdst);
  assign rs_mem_s = reg_match(ID_Rs, MEM_Rdst);
  assign rt_ex_s  = reg_match(ID_Rt, EX_Rdst);
  assign rt_mem_s = reg_match(ID_Rt, MEM_Rdst);

`ifdef HAZARD_FWD_EN
  // Only results that cannot be forwarded in time cause a stall.
  assign data_hazard_s =
      (ID_Needs_Rs && ((rs_ex_s && EX_RegW) || (rs_mem_s && MEM_MemR))) ||
      (ID_Wants_Rs && rs_ex_s && EX_MemR) ||
      (ID_Needs_Rt && ((rt_ex_s && EX_RegW) || (rt_mem_s && MEM_MemR))) ||
      (ID_Wants_Rt && rt_ex_s && EX_MemR);
  assign unused_s = MEM_RegW;
`else
  assign data_hazard_s =
      ((ID_Wants_Rs || ID_Needs_Rs) && ((rs_ex_s && EX_RegW) || (rs_mem_s && MEM_RegW))) ||
      ((ID_Wants_Rt || ID_Needs_Rt) && ((rt_ex_s && EX_RegW) || (rt_mem_s && MEM_RegW)));
  assign unused_s = EX_MemR ^ MEM_MemR;
`endif

  assign md_hazard_s = ID_MD_use && ((md_state_s != MD_IDLE) || EX_MD_start);

  // Stall/flush priority: flush, then memory wait, then hazard bubble.
  always_comb begin
    PC_Stall     = 1'b0;
    IF_ID_Stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_Stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_Stall = 1'b0;
    if (ext_flush) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (mem_busy) begin
      PC_Stall     = 1'b1;
      IF_ID_Stall  = 1'b1;
      ID_EX_Stall  = 1'b1;
      EX_MEM_Stall = 1'b1;
    end else if (data_hazard_s || md_hazard_s) begin
      PC_Stall    = 1'b1;
      IF_ID_Stall = 1'b1;
      ID_EX_flush = 1'b1;
    end else begin
      PC_Stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected outputs are queued when the
// stimulus is applied and compared against the DUT one step later.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rdst, MEM_Rdst;
  logic       ID_Wants_Rs, ID_Needs_Rs, ID_Wants_Rt, ID_Needs_Rt, ID_MD_use;
  logic       EX_RegW, EX_MemR, MEM_RegW, MEM_MemR;
  logic       EX_MD_start, EX_MD_is_div, mem_busy, ext_flush;
  logic       PC_Stall, IF_ID_Stall, IF_ID_flush, ID_EX_Stall, ID_EX_flush, EX_MEM_Stall;
  logic       MD_busy, MD_done;
  logic [1:0] md_state;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_Wants_Rs(ID_Wants_Rs), .ID_Needs_Rs(ID_Needs_Rs),
    .ID_Wants_Rt(ID_Wants_Rt), .ID_Needs_Rt(ID_Needs_Rt),
    .ID_MD_use(ID_MD_use),
    .EX_Rdst(EX_Rdst), .MEM_Rdst(MEM_Rdst),
    .EX_RegW(EX_RegW), .EX_MemR(EX_MemR), .MEM_RegW(MEM_RegW), .MEM_MemR(MEM_MemR),
    .EX_MD_start(EX_MD_start), .EX_MD_is_div(EX_MD_is_div),
    .mem_busy(mem_busy), .ext_flush(ext_flush),
    .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_Stall(ID_EX_Stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_Stall(EX_MEM_Stall),
    .MD_busy(MD_busy), .MD_done(MD_done), .md_state(md_state)
  );

  // {PC_Stall, IF_ID_Stall, IF_ID_flush, ID_EX_Stall, ID_EX_flush, EX_MEM_Stall}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_HAZ   = 6'b110010;
  localparam logic [5:0] C_FLUSH = 6'b001010;
  localparam logic [5:0] C_BUSY  = 6'b110101;
`ifdef HAZARD_FWD_EN
  localparam logic [5:0] C_NOFWD = C_NONE;
`else
  localparam logic [5:0] C_NOFWD = C_HAZ;
`endif

  typedef struct packed {
    logic [5:0] ctl;
    logic       busy;
    logic       done;
    logic [1:0] st;
  } exp_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       wrs, nrs, wrt, nrt;
    logic [4:0] exd;
    logic       exw, exm;
    logic [4:0] memd;
    logic       memw, memm;
    logic [5:0] ctl;
  } stim_t;

  exp_t sb_q[$];
  exp_t obs, e;
  int   total = 0;
  int   bad   = 0;

  assign obs = '{ctl: {PC_Stall, IF_ID_Stall, IF_ID_flush, ID_EX_Stall, ID_EX_flush, EX_MEM_Stall},
                 busy: MD_busy, done: MD_done, st: md_state};

  // Sequencer reference: start seen at cycle 0, RUN for lat-1 cycles, DONE at lat.
  function automatic exp_t md_exp(input int i, input int lat, input logic [5:0] ctl);
    exp_t r;
    r.ctl = ctl;
    if (i >= 1 && i < lat) begin r.busy = 1'b1; r.done = 1'b0; r.st = 2'd1; end
    else if (i == lat)     begin r.busy = 1'b1; r.done = 1'b1; r.st = 2'd2; end
    else                   begin r.busy = 1'b0; r.done = 1'b0; r.st = 2'd0; end
    return r;
  endfunction

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rdst = 5'd0; MEM_Rdst = 5'd0;
    ID_Wants_Rs = 1'b0; ID_Needs_Rs = 1'b0; ID_Wants_Rt = 1'b0; ID_Needs_Rt = 1'b0;
    ID_MD_use = 1'b0; EX_RegW = 1'b0; EX_MemR = 1'b0; MEM_RegW = 1'b0; MEM_MemR = 1'b0;
    EX_MD_start = 1'b0; EX_MD_is_div = 1'b0; mem_busy = 1'b0; ext_flush = 1'b0;
  endtask

  task automatic apply(input stim_t s);
    ID_Rs = s.rs; ID_Rt = s.rt;
    ID_Wants_Rs = s.wrs; ID_Needs_Rs = s.nrs; ID_Wants_Rt = s.wrt; ID_Needs_Rt = s.nrt;
    EX_Rdst = s.exd; EX_RegW = s.exw; EX_MemR = s.exm;
    MEM_Rdst = s.memd; MEM_RegW = s.memw; MEM_MemR = s.memm;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    sb_q.push_back('{C_NONE, 1'b0, 1'b0, 2'd0});
    #1;
    e = sb_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset got=%b want=%b", obs, e); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    EX_MemR = 1'b1; EX_RegW = 1'b1; EX_Rdst = 5'd5; ID_Rs = 5'd5; ID_Wants_Rs = 1'b1;
    sb_q.push_back('{C_HAZ, 1'b0, 1'b0, 2'd0});
    #1;
    e = sb_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL load_use got=%b want=%b", obs, e); end
    @(negedge clk);
    EX_MemR = 1'b0; EX_RegW = 1'b0; EX_Rdst = 5'd0;
    sb_q.push_back('{C_NONE, 1'b0, 1'b0, 2'd0});
    #1;
    e = sb_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL load_use_release got=%b want=%b", obs, e); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    clear_inputs();
    EX_Rdst = 5'd0; EX_MemR = 1'b1; EX_RegW = 1'b1; ID_Rs = 5'd0;
    ID_Wants_Rs = 1'b1; ID_Needs_Rs = 1'b1; MEM_RegW = 1'b1; MEM_MemR = 1'b1;
    sb_q.push_back('{C_NONE, 1'b0, 1'b0, 2'd0});
    #1;
    e = sb_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL zero_reg got=%b want=%b", obs, e); end
  endtask

  task automatic test_data_patterns();
    stim_t tbl[6];
    //        rs     rt     wrs  nrs  wrt  nrt  exd    exw  exm  memd   memw memm ctl
    tbl[0] = '{5'd0, 5'd3, 1'b0,1'b0,1'b0,1'b1, 5'd3, 1'b1,1'b0, 5'd0, 1'b0,1'b0, C_HAZ};
    tbl[1] = '{5'd9, 5'd0, 1'b0,1'b1,1'b0,1'b0, 5'd0, 1'b0,1'b0, 5'd9, 1'b1,1'b1, C_HAZ};
    tbl[2] = '{5'd4, 5'd0, 1'b1,1'b0,1'b0,1'b0, 5'd4, 1'b1,1'b0, 5'd0, 1'b0,1'b0, C_NOFWD};
    tbl[3] = '{5'd6, 5'd0, 1'b0,1'b1,1'b0,1'b0, 5'd7, 1'b1,1'b1, 5'd8, 1'b1,1'b1, C_NONE};
    tbl[4] = '{5'd0, 5'd7, 1'b0,1'b0,1'b1,1'b0, 5'd0, 1'b0,1'b0, 5'd7, 1'b1,1'b0, C_NOFWD};
    tbl[5] = '{5'd0, 5'd12,1'b0,1'b0,1'b1,1'b0, 5'd12,1'b0,1'b0, 5'd0, 1'b0,1'b0, C_NONE};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      apply(tbl[i]);
      sb_q.push_back('{tbl[i].ctl, 1'b0, 1'b0, 2'd0});
      #1;
      e = sb_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL data_pattern_%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_priority();
    logic [1:0] fm;
    logic [5:0] want;
    for (int i = 0; i < 4; i++) begin
      fm = 2'(i);
      @(negedge clk);
      clear_inputs();
      EX_MemR = 1'b1; EX_RegW = 1'b1; EX_Rdst = 5'd5; ID_Rs = 5'd5; ID_Wants_Rs = 1'b1;
      ext_flush = fm[1]; mem_busy = fm[0];
      want = fm[1] ? C_FLUSH : (fm[0] ? C_BUSY : C_HAZ);
      sb_q.push_back('{want, 1'b0, 1'b0, 2'd0});
      #1;
      e = sb_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL priority_%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_divide();
    @(negedge clk);
    clear_inputs();
    ID_MD_use = 1'b1;
    for (int i = 0; i <= 33; i++) begin
      if (i > 0) @(negedge clk);
      EX_MD_start = (i == 0); EX_MD_is_div = 1'b1;
      sb_q.push_back(md_exp(i, 32, (i <= 32) ? C_HAZ : C_NONE));
      #1;
      e = sb_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL divide_cycle_%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    @(negedge clk);
    clear_inputs();
    $display("note: deliberate illegal EX_MD_start while RUN at cycle 1");
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) @(negedge clk);
      EX_MD_start = (i == 0) || (i == 1) || (i == 4);
      x = (i <= 4) ? md_exp(i, 4, C_NONE) : md_exp(i - 4, 4, C_NONE);
      sb_q.push_back(x);
      #1;
      e = sb_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL back_to_back_cycle_%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_md_under_flush();
    @(negedge clk);
    clear_inputs();
    ID_MD_use = 1'b1; ext_flush = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) @(negedge clk);
      EX_MD_start = (i == 0);
      sb_q.push_back(md_exp(i, 4, C_FLUSH));
      #1;
      e = sb_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL md_under_flush_cycle_%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    clear_inputs();
    EX_MD_start = 1'b1; EX_MD_is_div = 1'b1;
    @(negedge clk);
    EX_MD_start = 1'b0;
    repeat (20) @(negedge clk);
    // 21 edges since start: counter is at 10
    #1;
    sb_q.push_back('{C_NONE, 1'b1, 1'b0, 2'd1});
    e = sb_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL pre_reset_run got=%b want=%b", obs, e); end
    rst = 1'b0;
    sb_q.push_back('{C_NONE, 1'b0, 1'b0, 2'd0});
    #1;
    e = sb_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL async_reset_mid_run got=%b want=%b", obs, e); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sb_q.push_back('{C_NONE, 1'b0, 1'b0, 2'd0});
      #1;
      e = sb_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL post_reset_cycle_%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_data_patterns();
    test_priority();
    test_divide();
    test_back_to_back();
    test_md_under_flush();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: DIV_CYCLES, default 32, divide latency in cycles; MUL_CYCLES, default 4, multiply latency in cycles; both SHALL be at least 2.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
REQ-005 ID_Wants_Rs, ID_Needs_Rs, ID_Wants_Rt, ID_Needs_Rt  in  1 each  operand used in EX (Wants) / in ID (Needs).
REQ-006 ID_MD_use  in  1  ID instruction is a mul/div or reads HI/LO.
REQ-007 EX_Rdst, MEM_Rdst  in  5 each; EX_RegW, EX_MemR, MEM_RegW, MEM_MemR  in  1 each  producer info.
REQ-008 EX_MD_start, EX_MD_is_div  in  1 each  mul/div issued in EX this cycle, and its kind.
REQ-009 mem_busy  in  1  data memory not ready; ext_flush  in  1  exception/redirect flush.
REQ-010 Outputs: PC_Stall, IF_ID_Stall, IF_ID_flush, ID_EX_Stall, ID_EX_flush, EX_MEM_Stall  out  1 each; MD_busy, MD_done  out  1 each; md_state  out  2.

Function
REQ-011 Register match SHALL require equal 5-bit index and index != 0.
REQ-012 With forwarding, data hazard SHALL be: Needs_x matching EX_Rdst with EX_RegW; or Needs_x matching MEM_Rdst with MEM_MemR; or Wants_x matching EX_Rdst with EX_MemR.
REQ-013 md_hazard SHALL be ID_MD_use while md_state != IDLE, or ID_MD_use while EX_MD_start.
REQ-014 Priority: ext_flush > mem_busy > md_hazard/data hazard > none.
REQ-015 ext_flush: IF_ID_flush=1, ID_EX_flush=1, all stalls 0.
REQ-016 mem_busy (no flush): PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall all 1, flushes 0.
REQ-017 Hazard only: PC_Stall=1, IF_ID_Stall=1, ID_EX_flush=1 (bubble), others 0.
REQ-018 Stall/flush outputs SHALL be combinational from current inputs and md_state, zero added latency.
REQ-019 FSM states IDLE(0), RUN(1), DONE(2); 5-bit down-counter cnt.
REQ-020 IDLE + EX_MD_start: go RUN, cnt = (is_div ? DIV_CYCLES : MUL_CYCLES) - 2.
REQ-021 RUN: cnt decrements; at cnt==0 go DONE; total RUN cycles = latency-1.
REQ-022 DONE: MD_done=1 for exactly one cycle, then IDLE; DONE + EX_MD_start SHALL go directly to RUN.
REQ-023 MD_busy SHALL be 1 in RUN and DONE.
REQ-024 EX_MD_start in RUN SHALL be ignored; the bench flags it as illegal.
REQ-025 ext_flush and mem_busy SHALL NOT abort or pause a running operation.

Reset
REQ-026 rst low: md_state=IDLE, cnt=0, MD_busy=0, MD_done=0 immediately; combinational outputs follow from inputs.
REQ-027 Reset mid-RUN SHALL discard the operation; no MD_done pulse.

Configuration
REQ-028 With HAZARD_FWD_EN defined, the hazard rule SHALL be REQ-012.
REQ-029 Without it, hazard SHALL be (Wants_x or Needs_x) matching EX_Rdst with EX_RegW, or MEM_Rdst with MEM_RegW; md logic unchanged.

Structure
REQ-030 State encoding and default latencies SHALL live in the shared package mips_pkg.
REQ-031 The mul/div sequencer (FSM + counter) SHALL be the sub-module md_seq; hazard compare and priority stay in hazard_ctrl.

Verification
REQ-032 Load-use: EX_MemR=1, EX_RegW=1, EX_Rdst=5; ID_Rs=5, ID_Wants_Rs=1 -> PC_Stall=1, IF_ID_Stall=1, ID_EX_flush=1 for 1 cycle.
REQ-033 $zero: EX_Rdst=0, EX_MemR=1, ID_Rs=0, ID_Wants_Rs=1 -> no stall.
REQ-034 Divide: EX_MD_start=1, EX_MD_is_div=1 -> MD_busy 1 for 32 cycles, MD_done on cycle 32; ID_MD_use=1 throughout -> stall every one of those cycles.
REQ-035 Simultaneous ext_flush=1, mem_busy=1, data hazard -> IF_ID_flush=1, ID_EX_flush=1, all stalls 0.
REQ-036 rst low at RUN cnt=10 -> md_state=0 and MD_busy=0 without a clock edge; no MD_done after release.
REQ-037 Without HAZARD_FWD_EN: MEM_RegW=1, MEM_Rdst=7, ID_Rt=7, ID_Wants_Rt=1 -> stall; with the macro defined -> no stall.
